// File: rtl/vga_frame_reader.sv
// Scans a grayscale framebuffer and drives VGA timing through a 2-stage address/data pipeline.
// Define SCALE2X_EN for 2x pixel doubling over the full screen instead of a centred 1:1 window.
module vga_frame_reader #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33,
  parameter int unsigned IMG_W  = 320,
  parameter int unsigned IMG_H  = 240,
  parameter logic [7:0]  BORDER = 8'h00
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FRAME_VALID,
  input  logic [7:0]  PIXEL_IN,
  output logic [16:0] R_ADDR,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        FRAME_START
);
  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW    = $clog2(H_TOT);
  localparam int unsigned VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_VIS);
  localparam logic [HW-1:0] HS_BEG = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_VIS);
  localparam logic [VW-1:0] VS_BEG = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_VIS + V_FP + V_SYNC);
`ifndef SCALE2X_EN
  localparam logic [HW-1:0] X_BEG     = HW'((H_VIS - IMG_W) / 2);
  localparam logic [HW-1:0] X_END     = HW'((H_VIS + IMG_W) / 2);
  localparam logic [VW-1:0] Y_BEG     = VW'((V_VIS - IMG_H) / 2);
  localparam logic [VW-1:0] Y_END     = VW'((V_VIS + IMG_H) / 2);
  localparam logic [16:0]   ADDR_LAST = 17'(IMG_W * IMG_H - 1);
`endif

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          r_show;
  logic [16:0]   r_addr;
`ifdef SCALE2X_EN
  logic [16:0]   r_base;
  logic [16:0]   w_addr;
`else
  logic [16:0]   r_acnt;
`endif
  logic w_h_last, w_frame_end, w_active, w_hs, w_vs, w_win;
  logic r_act1, r_hs1, r_vs1, r_img1, r_fs1;
  logic [7:0] r_rgb;
  logic r_hs2, r_vs2, r_blank2, r_fs2;

  always_comb begin
    w_h_last    = (r_h == H_LAST);
    w_frame_end = w_h_last && (r_v == V_LAST);
    w_active    = (r_h < H_ACT) && (r_v < V_ACT);
    w_hs        = !((r_h >= HS_BEG) && (r_h < HS_END));
    w_vs        = !((r_v >= VS_BEG) && (r_v < VS_END));
`ifdef SCALE2X_EN
    w_win       = w_active;
    w_addr      = r_base + 17'(r_h >> 1);
`else
    w_win       = (r_h >= X_BEG) && (r_h < X_END) && (r_v >= Y_BEG) && (r_v < Y_END);
`endif
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_h    <= '0;
      r_v    <= '0;
      r_show <= 1'b0;
    end else begin
      r_h <= w_h_last ? '0 : r_h + HW'(1);
      if (w_h_last) r_v <= (r_v == V_LAST) ? '0 : r_v + VW'(1);
      // Image selection only switches at the frame boundary
      if (w_frame_end) r_show <= FRAME_VALID;
    end
  end

`ifdef SCALE2X_EN
  // r_base is the address of the current source row; it advances after every odd line
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_addr <= '0;
      r_base <= '0;
    end else begin
      if (w_win) r_addr <= w_addr;
      if (w_frame_end) r_base <= '0;
      else if (w_h_last && r_v[0] && (r_v < V_ACT)) r_base <= r_base + 17'(IMG_W);
    end
  end
`else
  // r_acnt is the next window address; it saturates on the last image pixel
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_addr <= '0;
      r_acnt <= '0;
    end else if (w_frame_end) begin
      r_acnt <= '0;
    end else if (w_win) begin
      r_addr <= r_acnt;
      if (r_acnt != ADDR_LAST) r_acnt <= r_acnt + 17'd1;
    end
  end
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_act1   <= 1'b0;
      r_hs1    <= 1'b1;
      r_vs1    <= 1'b1;
      r_img1   <= 1'b0;
      r_fs1    <= 1'b0;
      r_rgb    <= 8'h00;
      r_hs2    <= 1'b1;
      r_vs2    <= 1'b1;
      r_blank2 <= 1'b0;
      r_fs2    <= 1'b0;
    end else begin
      r_act1   <= w_active;
      r_hs1    <= w_hs;
      r_vs1    <= w_vs;
      r_img1   <= w_win && r_show;
      r_fs1    <= (r_h == '0) && (r_v == '0);
      r_rgb    <= r_img1 ? PIXEL_IN : (r_act1 ? BORDER : 8'h00);
      r_hs2    <= r_hs1;
      r_vs2    <= r_vs1;
      r_blank2 <= r_act1;
      r_fs2    <= r_fs1;
    end
  end

  assign R_ADDR      = r_addr;
  assign VGA_R       = r_rgb;
  assign VGA_G       = r_rgb;
  assign VGA_B       = r_rgb;
  assign VGA_HS      = r_hs2;
  assign VGA_VS      = r_vs2;
  assign VGA_BLANK_N = r_blank2;
  assign FRAME_START = r_fs2;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader on a reduced timing geometry; a per-pixel reference model feeds a
// scoreboard queue that is checked as each pixel leaves the 2-stage pipeline.
module tb_vga_frame_reader;
  localparam int H_VIS = 20, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_VIS = 12, V_FP = 1, V_SYNC = 2, V_BP = 2;
`ifdef SCALE2X_EN
  localparam int IMG_W = 10, IMG_H = 6;
`else
  localparam int IMG_W = 8, IMG_H = 6;
`endif
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int X0 = (H_VIS - IMG_W) / 2;
  localparam int Y0 = (V_VIS - IMG_H) / 2;
  localparam logic [7:0] BORDER = 8'h00;

  typedef struct {
    logic [7:0]  rgb;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        fs;
    logic [16:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        RESET;
  logic        FRAME_VALID;
  logic [7:0]  PIXEL_IN;
  logic [16:0] R_ADDR;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N, FRAME_START;

  exp_t q[$];
  int   mh, mv, mf, addr_m, cyc;
  logic show_m;
  int   n_pass = 0;
  int   n_total = 0;

  // Framebuffer contents: low address byte with the MSB flipped so pixel 0 differs from BORDER
  function automatic logic [7:0] ram(input logic [16:0] a);
    return a[7:0] ^ 8'h80;
  endfunction

  assign PIXEL_IN = ram(R_ADDR);

  vga_frame_reader #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .IMG_W(IMG_W), .IMG_H(IMG_H), .BORDER(BORDER)
  ) dut (
    .CLK(clk), .RESET(RESET), .FRAME_VALID(FRAME_VALID), .PIXEL_IN(PIXEL_IN),
    .R_ADDR(R_ADDR), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .FRAME_START(FRAME_START)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: got %0h expected %0h (h=%0d v=%0d f=%0d)", tag, got, want, mh, mv, mf);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, 32'(R_ADDR), 32'd0);
    chk({tag, "_r"}, 32'(VGA_R), 32'd0);
    chk({tag, "_g"}, 32'(VGA_G), 32'd0);
    chk({tag, "_b"}, 32'(VGA_B), 32'd0);
    chk({tag, "_hs"}, 32'(VGA_HS), 32'd1);
    chk({tag, "_vs"}, 32'(VGA_VS), 32'd1);
    chk({tag, "_blank"}, 32'(VGA_BLANK_N), 32'd0);
    chk({tag, "_fs"}, 32'(FRAME_START), 32'd0);
  endtask

  task automatic reset_model();
    exp_t e;
    e = '{rgb: 8'h00, hs: 1'b1, vs: 1'b1, blank: 1'b0, fs: 1'b0, addr: 17'd0};
    q.delete();
    q.push_back(e);
    mh = 0; mv = 0; mf = 0; addr_m = 0; show_m = 1'b0; cyc = 0;
  endtask

  // Push the expectation for the pixel the next edge processes, then check the pixel leaving
  task automatic step();
    exp_t e;
    logic act, win;
    act = (mh < H_VIS) && (mv < V_VIS);
`ifdef SCALE2X_EN
    win = act;
    if (win) addr_m = (mv / 2) * IMG_W + mh / 2;
`else
    win = (mh >= X0) && (mh < X0 + IMG_W) && (mv >= Y0) && (mv < Y0 + IMG_H);
    if (win) addr_m = (mv - Y0) * IMG_W + (mh - X0);
`endif
    e.addr  = 17'(addr_m);
    e.rgb   = (win && show_m) ? ram(e.addr) : (act ? BORDER : 8'h00);
    e.hs    = !((mh >= H_VIS + H_FP) && (mh < H_VIS + H_FP + H_SYNC));
    e.vs    = !((mv >= V_VIS + V_FP) && (mv < V_VIS + V_FP + V_SYNC));
    e.blank = act;
    e.fs    = (mh == 0) && (mv == 0);
    q.push_back(e);
    if (mh == H_TOT - 1 && mv == V_TOT - 1) show_m = FRAME_VALID;
    if (mh == H_TOT - 1) begin
      mh = 0;
      if (mv == V_TOT - 1) begin mv = 0; mf++; end
      else mv++;
    end else mh++;
    @(negedge clk);
    cyc++;
    if (q.size() >= 2) begin
      e = q.pop_front();
      chk("sb_r", 32'(VGA_R), 32'(e.rgb));
      chk("sb_g", 32'(VGA_G), 32'(e.rgb));
      chk("sb_b", 32'(VGA_B), 32'(e.rgb));
      chk("sb_hs", 32'(VGA_HS), 32'(e.hs));
      chk("sb_vs", 32'(VGA_VS), 32'(e.vs));
      chk("sb_blank", 32'(VGA_BLANK_N), 32'(e.blank));
      chk("sb_fs", 32'(FRAME_START), 32'(e.fs));
      chk("sb_addr", 32'(R_ADDR), 32'(q[0].addr));
    end
  endtask

  task automatic run_to(input int f, input int h, input int v);
    int n = 0;
    while (!(mf == f && mh == h && mv == v) && n < 4 * H_TOT * V_TOT) begin
      step();
      n++;
    end
    chk("run_to_reached", 32'(n < 4 * H_TOT * V_TOT), 32'd1);
  endtask

  initial begin
    RESET = 1'b1;
    FRAME_VALID = 1'b0;
    #3 RESET = 1'b0;
    #1 chk_reset("rst_async");
    repeat (3) begin
      @(negedge clk);
      chk_reset("rst_hold");
    end
    RESET = 1'b1;
    reset_model();

    // First HS falling edge: sync start plus the 2-stage pipeline
    do step(); while (VGA_HS !== 1'b0 && cyc < 2 * H_TOT);
    chk("hs_first_fall", 32'(cyc), 32'(H_VIS + H_FP + 2));

    // Valid frame before wrap: image appears in frame 1
    FRAME_VALID = 1'b1;
    run_to(1, X0, Y0);
    step();
    chk("addr_win_first", 32'(R_ADDR), 32'd0);
    step();
    chk("rgb_win_first", 32'(VGA_R), 32'(ram(17'd0)));

    // Drop mid-frame: frame 1 keeps the image, frame 2 becomes border
    run_to(1, X0 + IMG_W / 2, Y0 + IMG_H / 2);
    FRAME_VALID = 1'b0;
    // Rise mid-frame: rest of frame 2 stays border, frame 3 shows the image
    run_to(2, X0 + 2, Y0 + 2);
    FRAME_VALID = 1'b1;
    run_to(3, X0 + 4, Y0 + 3);

    // Asynchronous reset mid-frame, between clock edges
    #2 RESET = 1'b0;
    #1 chk_reset("rst_mid");
    repeat (2) begin
      @(negedge clk);
      chk_reset("rst_mid_hold");
    end
    RESET = 1'b1;
    reset_model();
    do step(); while (FRAME_START !== 1'b1 && cyc < 8);
    chk("fs_after_reset", 32'(cyc), 32'd2);

    run_to(1, 0, Y0 + IMG_H);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
